// File: rtl/fxp_arith_unit_if.sv
// Operand/result bundle for fxp_arith_unit: request side (en, stall, operands)
// and the registered result side (out, done).
interface fxp_arith_unit_if #(
   parameter int A_W   = 16,
   parameter int B_W   = 16,
   parameter int OUT_W = 16
);
   logic                    en;
   logic                    stall;
   logic signed [A_W-1:0]   a_in;
   logic signed [B_W-1:0]   b_in;
   logic signed [OUT_W-1:0] out;
   logic                    done;

   modport master (output en, stall, a_in, b_in, input out, done);
   modport slave  (input en, stall, a_in, b_in, output out, done);
endinterface

// File: rtl/fxp_arith_unit.sv
// Pipelined signed fixed-point multiply or add with truncating rescale,
// saturation, global stall and a done pulse per accepted operation.
module fxp_arith_unit #(
   parameter     OP            = "MUL",
   parameter int INPUT_A_WIDTH = 16,
   parameter int INPUT_A_FRAC  = 15,
   parameter int INPUT_B_WIDTH = 16,
   parameter int INPUT_B_FRAC  = 15,
   parameter int OUTPUT_WIDTH  = 16,
   parameter int OUTPUT_FRAC   = 15,
   parameter int DELAY         = 3
) (
   input logic             clk,
   input logic             reset,
   fxp_arith_unit_if.slave bus
);
   localparam int AW  = INPUT_A_WIDTH;
   localparam int AF  = INPUT_A_FRAC;
   localparam int BW  = INPUT_B_WIDTH;
   localparam int BF  = INPUT_B_FRAC;
   localparam int OW  = OUTPUT_WIDTH;
   localparam int OF  = OUTPUT_FRAC;
   localparam int PW  = AW + BW;
   localparam int MF  = (AF > BF) ? AF : BF;
   localparam int IA  = AW - AF;
   localparam int IB  = BW - BF;
   localparam int SW  = ((IA > IB) ? IA : IB) + MF + 1;
   localparam int SHA = MF - AF;
   localparam int SHB = MF - BF;
   localparam int RW  = (PW > SW) ? PW : SW;
   localparam int RF  = (OP == "MUL") ? (AF + BF) : MF;
   localparam int SHR = (RF > OF) ? (RF - OF) : 0;
   localparam int SHL = (OF > RF) ? (OF - RF) : 0;
   // Working width leaves headroom for the largest left shift plus a sign bit
   localparam int EW  = (((RW + OF) > OW) ? (RW + OF) : OW) + 1;

   localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   generate
      if (OP != "MUL" && OP != "ADD") begin : g_bad_op
         $error("fxp_arith_unit: OP must be MUL or ADD");
      end
      if (DELAY < 1) begin : g_bad_delay
         $error("fxp_arith_unit: DELAY must be at least 1");
      end
   endgenerate

   function automatic logic signed [EW-1:0] rescale(input logic signed [EW-1:0] v);
      return (v >>> SHR) <<< SHL;
   endfunction

   function automatic logic signed [OW-1:0] saturate(input logic signed [EW-1:0] v);
      if (v > SAT_MAX) return SAT_MAX[OW-1:0];
      if (v < SAT_MIN) return SAT_MIN[OW-1:0];
      return v[OW-1:0];
   endfunction

   logic signed [AW-1:0] a_p0;
   logic signed [BW-1:0] b_p0;
   logic signed [PW-1:0] prod_p0;
   logic signed [SW-1:0] sum_p0;
   logic signed [EW-1:0] raw_p0;
   logic signed [OW-1:0] result_p0;

   assign a_p0      = bus.a_in;
   assign b_p0      = bus.b_in;
   assign prod_p0   = PW'(a_p0) * PW'(b_p0);
   assign sum_p0    = (SW'(a_p0) <<< SHA) + (SW'(b_p0) <<< SHB);
   assign raw_p0    = (OP == "MUL") ? EW'(prod_p0) : EW'(sum_p0);
   assign result_p0 = saturate(rescale(raw_p0));

   // ---- stage registers; the last one doubles as the output register ----
   logic signed [OW-1:0] data_p [DELAY];
   logic [DELAY-1:0]     vld_p;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p <= '0;
         for (int i = 0; i < DELAY; i++) data_p[i] <= '0;
      end else if (!bus.stall) begin
         vld_p[0] <= bus.en;
         if (bus.en) data_p[0] <= result_p0;
         // Data only moves with a valid beat so out holds across bubbles
         for (int i = 1; i < DELAY; i++) begin
            vld_p[i] <= vld_p[i-1];
            if (vld_p[i-1]) data_p[i] <= data_p[i-1];
         end
      end
   end

   assign bus.out  = data_p[DELAY-1];
   assign bus.done = vld_p[DELAY-1];
endmodule

// File: tb/tb_fxp_arith_unit.sv
// Directed bench: a Q1.15 multiplier (DELAY=3) and a Q1.15 adder (DELAY=1)
// sharing clock and reset, checked against hand-computed values.
module tb_fxp_arith_unit;
   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   fxp_arith_unit_if #(.A_W(16), .B_W(16), .OUT_W(16)) mul_if ();
   fxp_arith_unit_if #(.A_W(16), .B_W(16), .OUT_W(16)) add_if ();

   fxp_arith_unit #(.OP("MUL"), .DELAY(3)) u_mul (.clk(clk), .reset(reset), .bus(mul_if));
   fxp_arith_unit #(.OP("ADD"), .DELAY(1)) u_add (.clk(clk), .reset(reset), .bus(add_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mul_single(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] exp);
      mul_if.en = 1'b1; mul_if.a_in = a; mul_if.b_in = b;
      step();
      mul_if.en = 1'b0;
      check({tag, " done k"}, {15'd0, mul_if.done}, 16'd0);
      step();
      check({tag, " done k+1"}, {15'd0, mul_if.done}, 16'd0);
      step();
      check({tag, " done k+2"}, {15'd0, mul_if.done}, 16'd1);
      check({tag, " out"}, mul_if.out, exp);
      step();
      check({tag, " done k+3"}, {15'd0, mul_if.done}, 16'd0);
      check({tag, " out hold"}, mul_if.out, exp);
   endtask

   task automatic add_single(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] exp);
      add_if.en = 1'b1; add_if.a_in = a; add_if.b_in = b;
      step();
      add_if.en = 1'b0;
      check({tag, " done"}, {15'd0, add_if.done}, 16'd1);
      check({tag, " out"}, add_if.out, exp);
      step();
      check({tag, " done after"}, {15'd0, add_if.done}, 16'd0);
      check({tag, " out hold"}, add_if.out, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] sb [4];
      logic [15:0] sexp [4];
      sb   = '{16'h0800, 16'h1000, 16'h2000, 16'h4000};
      sexp = '{16'h0400, 16'h0800, 16'h1000, 16'h2000};

      reset = 1'b0;
      mul_if.en = 1'b0; mul_if.stall = 1'b0; mul_if.a_in = '0; mul_if.b_in = '0;
      add_if.en = 1'b0; add_if.stall = 1'b0; add_if.a_in = '0; add_if.b_in = '0;
      repeat (2) step();
      check("rst mul out",  mul_if.out, 16'h0000);
      check("rst mul done", {15'd0, mul_if.done}, 16'd0);
      check("rst add out",  add_if.out, 16'h0000);
      check("rst add done", {15'd0, add_if.done}, 16'd0);
      reset = 1'b1;
      step();
      check("idle mul done", {15'd0, mul_if.done}, 16'd0);

      mul_single("mul half*half", 16'h4000, 16'h4000, 16'h2000);
      mul_single("mul sat -1*-1", 16'h8000, 16'h8000, 16'h7FFF);
      mul_single("mul floor neg", 16'hFFFF, 16'h4000, 16'hFFFF);
      mul_single("mul trunc pos", 16'h0001, 16'h4000, 16'h0000);

      add_single("add basic",   16'h2000, 16'h1000, 16'h3000);
      add_single("add sat pos", 16'h6000, 16'h4000, 16'h7FFF);
      add_single("add sat neg", 16'h8000, 16'hC000, 16'h8000);

      // Streaming: four back-to-back multiplies
      for (int i = 0; i < 8; i++) begin
         if (i < 4) begin
            mul_if.en = 1'b1; mul_if.a_in = 16'h4000; mul_if.b_in = sb[i];
         end else begin
            mul_if.en = 1'b0;
         end
         step();
         if (i >= 2 && i < 6) begin
            check($sformatf("stream done %0d", i), {15'd0, mul_if.done}, 16'd1);
            check($sformatf("stream out %0d", i),  mul_if.out, sexp[i-2]);
         end else begin
            check($sformatf("stream done %0d", i), {15'd0, mul_if.done}, 16'd0);
         end
      end

      // Stall for two edges mid-flight, with en asserted during the stall
      mul_if.en = 1'b1; mul_if.a_in = 16'h4000; mul_if.b_in = 16'h2000;
      step();
      mul_if.en = 1'b0;
      check("stall done k", {15'd0, mul_if.done}, 16'd0);
      step();
      check("stall done k+1", {15'd0, mul_if.done}, 16'd0);
      mul_if.stall = 1'b1; mul_if.en = 1'b1; mul_if.a_in = 16'h7FFF; mul_if.b_in = 16'h7FFF;
      step();
      check("stall done k+2", {15'd0, mul_if.done}, 16'd0);
      check("stall out k+2",  mul_if.out, 16'h2000);
      step();
      check("stall done k+3", {15'd0, mul_if.done}, 16'd0);
      check("stall out k+3",  mul_if.out, 16'h2000);
      mul_if.stall = 1'b0; mul_if.en = 1'b0;
      step();
      check("stall done k+4", {15'd0, mul_if.done}, 16'd1);
      check("stall out k+4",  mul_if.out, 16'h1000);
      mul_if.stall = 1'b1; mul_if.en = 1'b1;
      step();
      check("stall done held", {15'd0, mul_if.done}, 16'd1);
      check("stall out held",  mul_if.out, 16'h1000);
      mul_if.stall = 1'b0; mul_if.en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("post stall done %0d", i), {15'd0, mul_if.done}, 16'd0);
      end
      check("post stall out", mul_if.out, 16'h1000);

      // Async reset with ops in flight and done high
      mul_if.a_in = 16'h4000;
      for (int i = 0; i < 3; i++) begin
         mul_if.en = 1'b1; mul_if.b_in = sb[i];
         step();
      end
      mul_if.en = 1'b0;
      check("pre-rst done", {15'd0, mul_if.done}, 16'd1);
      check("pre-rst out",  mul_if.out, 16'h0400);
      #2;
      reset = 1'b0;
      #1;
      check("async rst mul out",  mul_if.out, 16'h0000);
      check("async rst mul done", {15'd0, mul_if.done}, 16'd0);
      check("async rst add out",  add_if.out, 16'h0000);
      #2;
      reset = 1'b1;
      mul_if.en = 1'b1; mul_if.a_in = 16'h6000; mul_if.b_in = 16'h4000;
      step();
      mul_if.en = 1'b0;
      check("rel done k", {15'd0, mul_if.done}, 16'd0);
      step();
      check("rel done k+1", {15'd0, mul_if.done}, 16'd0);
      step();
      check("rel done k+2", {15'd0, mul_if.done}, 16'd1);
      check("rel out",      mul_if.out, 16'h3000);
      step();
      check("rel done k+3", {15'd0, mul_if.done}, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
